uart_rx_8n1: RTL and testbench

Asynchronous serial receiver: deserializes an 8N1 frame (start bit 0, 8 data bits LSB first, stop bit 1) from a single input line into an 8-bit word. Fed by a board pin or the serial output of a parallel-to-serial shifter in the same fabric. The word is presented on a parallel bus with a one-cycle valid strobe, for FND/LED display logic or a downstream register. Bit timing comes from an internal counter that divides the system clock to the baud period and samples the line at mid-bit.

---
 rtl/uart_rx_8n1.sv | 129 ++++++++++++
 tb/tb_uart_rx_8n1.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 asynchronous serial receiver.
// Synchronises rx, finds the start-bit midpoint, then samples each data bit
// and the stop bit one bit period apart. Good frames update data with a
// one-cycle valid strobe; a low stop bit gives a one-cycle frame_err strobe
// and the receiver waits for the line to return high before re-arming.
module uart_rx_8n1 #(
    parameter int unsigned CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state, state_d;
    logic          rx_meta, rx_s;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [7:0]    sh, sh_d;
    logic [7:0]    data_d;
    logic          valid_d, frame_err_d;

    // Two-stage synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // Bit timing counter, shift register and registered output strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            bit_idx   <= '0;
            sh        <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cnt       <= cnt_d;
            bit_idx   <= bit_idx_d;
            sh        <= sh_d;
            data      <= data_d;
            valid     <= valid_d;
            frame_err <= frame_err_d;
        end
    end

    // Next-state, sampling and strobe generation.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt + CW'(1);
        bit_idx_d   = bit_idx;
        sh_d        = sh;
        data_d      = data;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_d     = '0;
                    sh_d      = {rx_s, sh[7:1]};
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = sh;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: self-checking bench for uart_rx_8n1 with CLKS_PER_BIT=16.
// Frames are driven onto rx with free-running delays (bit period jittered
// about the nominal 160 time units); every frame sent pushes the event it
// should produce (the byte, or 256 for a framing error) onto a queue that a
// monitor consumes whenever valid or frame_err pulses.
module tb_uart_rx_8n1;

    localparam int unsigned CPB    = 16;
    localparam int unsigned CLK_T  = 10;
    localparam int unsigned BIT_T  = CPB * CLK_T;
    localparam int          EV_ERR = 256;

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int          n_vec;
    int          n_err;
    int          exp_q[$];
    logic [7:0]  ref_data;
    int          mon_code;
    int          mon_exp;

    uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #(CLK_T / 2) clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one frame; leaves rx at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned bit_t);
        rx = 1'b0;
        #(bit_t);
        for (int unsigned i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_t);
        end
        rx = stop;
        #(bit_t);
    endtask

    task automatic wait_idle(input string tag);
        int unsigned k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check_val({tag, "_pending"}, exp_q.size(), 0);
        check_val({tag, "_busy"}, int'(busy), 0);
    endtask

    // Event monitor: pulses must match the expected queue; data must hold.
    always @(negedge clk) begin
        if (valid && frame_err) begin
            check_val("valid_ferr_excl", 1, 0);
        end else if (valid || frame_err) begin
            mon_code = valid ? int'(data) : EV_ERR;
            if (exp_q.size() == 0) begin
                check_val("unexpected_event", mon_code, -1);
            end else begin
                mon_exp = exp_q.pop_front();
                check_val("rx_event", mon_code, mon_exp);
                if (mon_exp < EV_ERR) ref_data = mon_exp[7:0];
            end
        end
        check_val("data_hold", int'(data), int'(ref_data));
    end

    initial begin
        logic [7:0]  b;
        int unsigned per;
        logic        bad;
        int unsigned k;

        n_vec    = 0;
        n_err    = 0;
        ref_data = 8'h00;
        rx       = 1'b1;
        reset_n  = 1'b0;
        repeat (5) @(posedge clk);
        reset_n = 1'b1;

        // Reset state held while the line idles
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check_val("rst_busy", int'(busy), 0);
            check_val("rst_valid", int'(valid), 0);
            check_val("rst_ferr", int'(frame_err), 0);
        end

        // Single frame
        @(posedge clk);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, BIT_T);
        wait_idle("single");

        // Back-to-back frames, no idle between them
        @(posedge clk);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        send_frame(8'h00, 1'b1, BIT_T);
        send_frame(8'hFF, 1'b1, BIT_T - 3);
        send_frame(8'h3C, 1'b1, BIT_T + 3);
        wait_idle("b2b");

        // Short glitch is rejected at the start-bit midpoint
        @(posedge clk);
        rx = 1'b0;
        repeat (4) @(posedge clk);
        rx = 1'b1;
        k = 0;
        while (busy && k < 16) begin
            @(negedge clk);
            k++;
        end
        check_val("glitch_busy", int'(busy), 0);
        repeat (20) @(posedge clk);

        // Framing error, held break, then a clean frame
        exp_q.push_back(EV_ERR);
        send_frame(8'h5A, 1'b0, BIT_T);
        repeat (40) @(posedge clk);
        check_val("break_busy", int'(busy), 1);
        check_val("break_pending", exp_q.size(), 0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check_val("break_release_busy", int'(busy), 0);
        @(posedge clk);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, BIT_T);
        wait_idle("ferr");

        // Asynchronous reset during data bit 4
        @(posedge clk);
        fork
            send_frame(8'hC3, 1'b1, BIT_T);
            begin
                #(BIT_T * 5 + BIT_T / 2 + 2);
                reset_n  = 1'b0;
                ref_data = 8'h00;
                #1;
                check_val("midrst_busy", int'(busy), 0);
                check_val("midrst_data", int'(data), 0);
                check_val("midrst_valid", int'(valid), 0);
            end
        join
        repeat (20) @(posedge clk);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        exp_q.push_back(8'h99);
        send_frame(8'h99, 1'b1, BIT_T);
        wait_idle("midrst");

        // Randomised frames: jittered baud, random gaps, occasional bad stop
        for (int n = 0; n < 24; n++) begin
            b   = 8'($urandom);
            per = $urandom_range(BIT_T - 4, BIT_T + 4);
            bad = ($urandom_range(0, 7) == 0);
            exp_q.push_back(bad ? EV_ERR : int'(b));
            send_frame(b, ~bad, per);
            if (bad) begin
                repeat ($urandom_range(0, 30)) @(posedge clk);
                rx = 1'b1;
                #(per * 2);
            end else begin
                #(per * $urandom_range(0, 2));
            end
        end
        wait_idle("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
